// File: rtl/multicycle_ctrl_fsm.sv
// Main control FSM for the multi-cycle CPU.
// Sequences fetch / decode / execute / memory / writeback and drives every
// datapath mux select and write strobe. Memory accesses use a ready handshake
// guarded by a wait-state watchdog; completed instructions are counted.
//
// Ports:
//   clk_i, rst_ni         clock, asynchronous active-low reset
//   opcode_i, funct_i     instruction fields, sampled in DECODE only
//   zero_i                ALU zero flag (consumed by the datapath in BRANCH)
//   mem_ready_i           memory completes the current access this cycle
//   mem_req_o ... reg_write_o  datapath controls (Moore decode of state)
//   illegal_o             sticky trap flag (bad opcode/funct or memory timeout)
//   state_o               current state encoding, for debug
//   retired_o             completed-instruction count, wraps
module multicycle_ctrl_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned CNT_W          = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [5:0]       opcode_i,
  input  logic [5:0]       funct_i,
  input  logic             zero_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_write_o,
  output logic             iord_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_write_cond_o,
  output logic [1:0]       pc_source_o,
  output logic             alu_src_a_o,
  output logic [1:0]       alu_src_b_o,
  output logic [1:0]       alu_op_o,
  output logic             reg_dst_o,
  output logic             mem_to_reg_o,
  output logic             reg_write_o,
  output logic             illegal_o,
  output logic [3:0]       state_o,
  output logic [CNT_W-1:0] retired_o
);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExec    = 4'd6,
    StRWb     = 4'd7,
    StBranch  = 4'd8,
    StJump    = 4'd9,
    StAddiEx  = 4'd10,
    StAddiWb  = 4'd11,
    StTrap    = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [7:0] TmoLast = 8'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [7:0]       tmo_q, tmo_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             illegal_q, illegal_d;

  // Raw (ungated) strobes decoded from state.
  logic mem_req, mem_write, ir_write, pc_write, pc_write_cond, reg_write;
  logic wait_cyc, timeout, retire;

  always_comb begin
    mem_req         = 1'b0;
    mem_write       = 1'b0;
    iord_o          = 1'b0;
    ir_write        = 1'b0;
    pc_write        = 1'b0;
    pc_write_cond   = 1'b0;
    pc_source_o     = 2'b00;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = 2'b00;
    alu_op_o        = 2'b00;
    reg_dst_o       = 1'b0;
    mem_to_reg_o    = 1'b0;
    reg_write       = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_req     = 1'b1;
        alu_src_b_o = 2'b01;
        ir_write    = mem_ready_i;
        pc_write    = mem_ready_i;
      end
      StDecode:  alu_src_b_o = 2'b11;
      StMemAddr: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      StMemRd: begin
        mem_req = 1'b1;
        iord_o  = 1'b1;
      end
      StMemWb: begin
        reg_write    = 1'b1;
        mem_to_reg_o = 1'b1;
      end
      StMemWr: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        iord_o    = 1'b1;
      end
      StExec: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = 2'b10;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst_o = 1'b1;
      end
      StBranch: begin
        alu_src_a_o   = 1'b1;
        alu_op_o      = 2'b01;
        pc_write_cond = 1'b1;
        pc_source_o   = 2'b01;
      end
      StJump: begin
        pc_write    = 1'b1;
        pc_source_o = 2'b10;
      end
      StAddiEx: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = 2'b10;
      end
      StAddiWb:  reg_write = 1'b1;
      default: ;
    endcase
  end

  // Strobes are forced low while reset is held so an aborted access writes nothing.
  assign mem_req_o       = mem_req & rst_ni;
  assign mem_write_o     = mem_write & rst_ni;
  assign ir_write_o      = ir_write & rst_ni;
  assign pc_write_o      = pc_write & rst_ni;
  assign pc_write_cond_o = pc_write_cond & rst_ni;
  assign reg_write_o     = reg_write & rst_ni;

  assign wait_cyc = mem_req & ~mem_ready_i;
  // A ready arriving on the last allowed cycle completes the access instead.
  assign timeout  = wait_cyc && (tmo_q == TmoLast);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      StFetch:  if (mem_ready_i) state_d = StDecode;
      StDecode: begin
        op_d = opcode_i;
        case (opcode_i)
          OpRType: begin
            if (funct_i inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) begin
              state_d = StExec;
            end else begin
              state_d = StTrap;
            end
          end
          OpLw, OpSw: state_d = StMemAddr;
          OpBeq:      state_d = StBranch;
          OpJ:        state_d = StJump;
          OpAddi:     state_d = StAddiEx;
          default:    state_d = StTrap;
        endcase
      end
      StMemAddr: state_d = (op_q == OpSw) ? StMemWr : StMemRd;
      StMemRd:   if (mem_ready_i) state_d = StMemWb;
      StMemWb:   state_d = StFetch;
      StMemWr:   if (mem_ready_i) state_d = StFetch;
      StExec:    state_d = StRWb;
      StRWb:     state_d = StFetch;
      StBranch:  state_d = StFetch;
      StJump:    state_d = StFetch;
      StAddiEx:  state_d = StAddiWb;
      StAddiWb:  state_d = StFetch;
      StTrap:    state_d = StTrap;
      default:   state_d = StTrap;
    endcase
    if (timeout) state_d = StTrap;
  end

  always_comb begin
    tmo_d = (state_d != state_q || !wait_cyc) ? 8'd0 : tmo_q + 8'd1;
    retire = (state_d == StFetch) &&
             (state_q inside {StMemWb, StMemWr, StRWb, StBranch, StJump, StAddiWb});
    retired_d = retire ? retired_q + CNT_W'(1) : retired_q;
    illegal_d = illegal_q | (state_d == StTrap);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StFetch;
      op_q      <= 6'd0;
      tmo_q     <= 8'd0;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      tmo_q     <= tmo_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  assign illegal_o = illegal_q;
  assign state_o   = state_q;
  assign retired_o = retired_q;

  // Branch resolution happens in the datapath via pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero_i;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
module tb_multicycle_ctrl_fsm;
  localparam int Tmo = 16;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic [5:0]  opcode_i, funct_i;
  logic        zero_i, mem_ready_i;
  logic        mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o;
  logic [1:0]  pc_source_o, alu_src_b_o, alu_op_o;
  logic        alu_src_a_o, reg_dst_o, mem_to_reg_o, reg_write_o, illegal_o;
  logic [3:0]  state_o;
  logic [31:0] retired_o;

  multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(Tmo), .CNT_W(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct_i(funct_i),
    .zero_i(zero_i), .mem_ready_i(mem_ready_i), .mem_req_o(mem_req_o),
    .mem_write_o(mem_write_o), .iord_o(iord_o), .ir_write_o(ir_write_o),
    .pc_write_o(pc_write_o), .pc_write_cond_o(pc_write_cond_o), .pc_source_o(pc_source_o),
    .alu_src_a_o(alu_src_a_o), .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o),
    .reg_dst_o(reg_dst_o), .mem_to_reg_o(mem_to_reg_o), .reg_write_o(reg_write_o),
    .illegal_o(illegal_o), .state_o(state_o), .retired_o(retired_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;
  int exp_ret = 0;
  int st_q[$];
  bit rdy_q[$];

  logic [15:0] obs_ctrl;
  assign obs_ctrl = {mem_req_o, mem_write_o, iord_o, ir_write_o, pc_write_o, pc_write_cond_o,
                     pc_source_o, alu_src_a_o, alu_src_b_o, alu_op_o, reg_dst_o, mem_to_reg_o,
                     reg_write_o};

  // Control table straight from the state descriptions.
  function automatic logic [15:0] exp_ctrl(int st, bit rdy);
    logic mr = 0, mw = 0, io = 0, ir = 0, pw = 0, pwc = 0, asa = 0, rd = 0, m2r = 0, rw = 0;
    logic [1:0] ps = 0, asb = 0, aop = 0;
    case (st)
      0:  begin mr = 1; ir = rdy; pw = rdy; asb = 2'b01; end
      1:  asb = 2'b11;
      2:  begin asa = 1; asb = 2'b10; end
      3:  begin mr = 1; io = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mr = 1; mw = 1; io = 1; end
      6:  begin asa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin asa = 1; aop = 2'b01; pwc = 1; ps = 2'b01; end
      9:  begin pw = 1; ps = 2'b10; end
      10: begin asa = 1; asb = 2'b10; end
      11: rw = 1;
      default: ;
    endcase
    return {mr, mw, io, ir, pw, pwc, ps, asa, asb, aop, rd, m2r, rw};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One cycle: drive inputs just after negedge, check before the next posedge.
  task automatic step(input int st, input bit rdy, input logic [5:0] op, input logic [5:0] fn);
    mem_ready_i = rdy;
    opcode_i    = (st == 1) ? op : 6'($urandom);
    funct_i     = (st == 1) ? fn : 6'($urandom);
    zero_i      = 1'($urandom);
    #1;
    chk($sformatf("state(exp %0d)", st), 32'(state_o), 32'(st));
    chk($sformatf("ctrl(st %0d rdy %0d)", st, rdy), 32'(obs_ctrl), 32'(exp_ctrl(st, rdy)));
    chk($sformatf("illegal(st %0d)", st), 32'(illegal_o), 32'(st == 12));
    @(negedge clk_i);
  endtask

  function automatic bit push_wait(int st, int w);
    for (int i = 0; i < w && i < Tmo; i++) begin
      st_q.push_back(st);
      rdy_q.push_back(1'b0);
    end
    if (w >= Tmo) begin
      st_q.push_back(12);
      rdy_q.push_back(1'b1);
      return 1'b1;
    end
    st_q.push_back(st);
    rdy_q.push_back(1'b1);
    return 1'b0;
  endfunction

  function automatic void push(int st);
    st_q.push_back(st);
    rdy_q.push_back(1'($urandom));
  endfunction

  // Expected state/ready script for one instruction; returns 1 if it traps.
  function automatic bit build(logic [5:0] op, logic [5:0] fn, int wf, int wm);
    st_q.delete();
    rdy_q.delete();
    if (push_wait(0, wf)) return 1'b1;
    push(1);
    if (op == 6'h00) begin
      if (fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin
        push(6); push(7); return 1'b0;
      end
      push(12); return 1'b1;
    end
    case (op)
      6'h23: begin push(2); if (push_wait(3, wm)) return 1'b1; push(4); return 1'b0; end
      6'h2B: begin push(2); return push_wait(5, wm); end
      6'h04: begin push(8); return 1'b0; end
      6'h02: begin push(9); return 1'b0; end
      6'h08: begin push(10); push(11); return 1'b0; end
      default: begin push(12); return 1'b1; end
    endcase
  endfunction

  task automatic do_reset();
    rst_ni = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    exp_ret = 0;
    chk("rst_state", 32'(state_o), 0);
    chk("rst_illegal", 32'(illegal_o), 0);
    chk("rst_retired", retired_o, 0);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    @(negedge clk_i);
    chk("rst_hold_state", 32'(state_o), 0);
    chk("rst_hold_ir_write", 32'(ir_write_o), 0);
    chk("rst_hold_pc_write", 32'(pc_write_o), 0);
    rst_ni = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int wf,
                           input int wm);
    bit trapped;
    trapped = build(op, fn, wf, wm);
    foreach (st_q[i]) step(st_q[i], rdy_q[i], op, fn);
    if (!trapped) begin
      exp_ret++;
      chk($sformatf("retired(op %0h)", op), retired_o, 32'(exp_ret));
    end else begin
      repeat (3) step(12, 1'($urandom), op, fn);
      chk($sformatf("trap_retired(op %0h)", op), retired_o, 32'(exp_ret));
      do_reset();
    end
  endtask

  function automatic int rand_wait();
    int r = $urandom_range(0, 19);
    int big[5] = '{14, 15, 16, 17, 20};
    if (r < 15) return r % 4;
    return big[r - 15];
  endfunction

  initial begin
    logic [5:0] legal_fn[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [5:0] op, fn;
    rst_ni = 1'b0;
    opcode_i = 6'd0;
    funct_i = 6'd0;
    zero_i = 1'b0;
    mem_ready_i = 1'b0;
    @(negedge clk_i);
    do_reset();

    run_instr(6'h00, 6'h20, 0, 0);  // add
    run_instr(6'h23, 6'h00, 0, 3);  // lw with 3 wait states
    run_instr(6'h04, 6'h00, 0, 0);  // beq
    run_instr(6'h04, 6'h00, 0, 0);
    run_instr(6'h2B, 6'h00, 1, 2);  // sw
    run_instr(6'h02, 6'h00, 0, 0);  // j
    run_instr(6'h08, 6'h00, 0, 0);  // addi
    run_instr(6'h3F, 6'h00, 0, 0);  // bad opcode
    run_instr(6'h00, 6'h07, 0, 0);  // bad funct
    run_instr(6'h00, 6'h20, 16, 0); // fetch timeout
    run_instr(6'h00, 6'h20, 15, 0); // ready on last allowed cycle
    run_instr(6'h23, 6'h00, 0, 16); // MEM_RD timeout

    // Reset in the middle of a store access.
    run_instr(6'h08, 6'h00, 0, 0);
    step(0, 1'b1, 6'h2B, 6'h00);
    step(1, 1'b0, 6'h2B, 6'h00);
    step(2, 1'b0, 6'h2B, 6'h00);
    step(5, 1'b0, 6'h2B, 6'h00);
    mem_ready_i = 1'b0;
    #2;
    chk("midwr_mem_write_before", 32'(mem_write_o), 1);
    rst_ni = 1'b0;
    #1;
    chk("midwr_mem_req", 32'(mem_req_o), 0);
    chk("midwr_mem_write", 32'(mem_write_o), 0);
    chk("midwr_state", 32'(state_o), 0);
    chk("midwr_retired", retired_o, 0);
    exp_ret = 0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 8))
        0: begin op = 6'h00; fn = legal_fn[$urandom_range(0, 4)]; end
        1: begin op = 6'h00; fn = 6'($urandom); end
        2: begin op = 6'h23; fn = 6'($urandom); end
        3: begin op = 6'h2B; fn = 6'($urandom); end
        4: begin op = 6'h04; fn = 6'($urandom); end
        5: begin op = 6'h02; fn = 6'($urandom); end
        6: begin op = 6'h08; fn = 6'($urandom); end
        default: begin op = 6'($urandom); fn = 6'($urandom); end
      endcase
      run_instr(op, fn, rand_wait(), rand_wait());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
- Main control state machine for the multi-cycle CPU.
- Consumes the opcode and funct fields produced by instrDecoder, plus the ALU zero flag and a memory-ready handshake.
- Sequences fetch, decode, execute, memory and writeback, driving every datapath mux select and write strobe.
- Adds a memory wait-state handshake with a timeout watchdog, and a retired-instruction counter.

Parameters:
- TIMEOUT_CYCLES, 16: maximum consecutive cycles with mem_req high and mem_ready low before trapping. Legal range 2..255.
- CNT_W, 32: width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instr[31:26] from instrDecoder; sampled only in DECODE.
- funct  in  6  instr[5:0] from instrDecoder; sampled only in DECODE.
- zero  in  1  ALU zero flag; used only in BRANCH.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_write  out  1  access is a write (meaningful only when mem_req=1).
- iord  out  1  address mux select: 0 = PC, 1 = ALUOut.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  PC load if zero=1.
- pc_source  out  2  PC mux select: 00 = ALU, 01 = ALUOut, 10 = jump target.
- alu_src_a  out  1  ALU A select: 0 = PC, 1 = rs1.
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- alu_op  out  2  ALU operation: 00 = add, 01 = sub, 10 = decode funct.
- reg_dst  out  1  destination select: 0 = rt, 1 = rd.
- mem_to_reg  out  1  writeback data select: 0 = ALUOut, 1 = MDR.
- reg_write  out  1  register file write enable.
- illegal  out  1  sticky; set on an unknown opcode or funct, or on a memory timeout.
- state  out  4  current state encoding, for debug.
- retired  out  CNT_W  count of completed instructions.

Behaviour:
- Reset:
  - rst_n low immediately forces state=FETCH(0), retired=0, illegal=0 and the timeout counter to 0.
  - While rst_n is low, all strobes (mem_req, ir_write, pc_write, pc_write_cond, reg_write, mem_write) are forced to 0 combinationally.
  - Reset asserted mid-access aborts the access with no writes.
- Outputs are a combinational decode of state (Moore), except ir_write and pc_write in FETCH, which also depend on mem_ready.
- State encodings: FETCH 0, DECODE 1, MEM_ADDR 2, MEM_RD 3, MEM_WB 4, MEM_WR 5, EXEC 6, R_WB 7, BRANCH 8, JUMP 9, ADDI_EX 10, ADDI_WB 11, TRAP 12.
- FETCH:
  - Outputs: mem_req=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_source=00.
  - ir_write = pc_write = mem_ready.
  - Next state: DECODE if mem_ready, else stay.
- DECODE:
  - Outputs: alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - Opcode dispatch:
    - 000000 → EXEC, but only if funct is one of 100000, 100010, 100100, 100101, 101010; any other funct → TRAP.
    - 100011 (lw) or 101011 (sw) → MEM_ADDR.
    - 000100 (beq) → BRANCH.
    - 000010 (j) → JUMP.
    - 001000 (addi) → ADDI_EX.
    - Anything else → TRAP.
- MEM_ADDR:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: MEM_RD for lw, MEM_WR for sw. Use a registered copy of opcode captured in DECODE.
- MEM_RD:
  - Outputs: mem_req=1, iord=1.
  - Next state: MEM_WB on mem_ready, else stay.
- MEM_WB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=1.
  - Next state: FETCH.
- MEM_WR:
  - Outputs: mem_req=1, mem_write=1, iord=1.
  - Next state: FETCH on mem_ready, else stay.
- EXEC:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=10.
  - Next state: R_WB.
- R_WB:
  - Outputs: reg_write=1, reg_dst=1, mem_to_reg=0.
  - Next state: FETCH.
- BRANCH:
  - Outputs: alu_src_a=1, alu_src_b=00, alu_op=01, pc_write_cond=1, pc_source=01.
  - Next state: FETCH.
- JUMP:
  - Outputs: pc_write=1, pc_source=10.
  - Next state: FETCH.
- ADDI_EX:
  - Outputs: alu_src_a=1, alu_src_b=10, alu_op=00.
  - Next state: ADDI_WB.
- ADDI_WB:
  - Outputs: reg_write=1, reg_dst=0, mem_to_reg=0.
  - Next state: FETCH.
- TRAP:
  - All strobes 0; illegal=1; state is held until reset.
  - retired does not increment on a trap.
- Latencies, counting zero wait states: R-type 4 cycles, lw 5, sw 4, beq 3, j 3, addi 4.
- Timeout counter:
  - Increments each cycle in which mem_req=1 and mem_ready=0.
  - Clears on mem_ready=1 and on any state change.
  - Reaching TIMEOUT_CYCLES → TRAP on the next edge.
  - mem_ready arriving in the same cycle the count reaches the limit wins: the access completes.
- retired:
  - Increments by 1 on each transition into FETCH from MEM_WB, MEM_WR, R_WB, BRANCH, JUMP or ADDI_WB.
  - Wraps modulo 2^CNT_W.
- Unused select outputs are driven to 0 in every state; no X values on outputs.

Test Plan:
- Reset, then instr=32'h014B4820 (add t1,t2,t3: opcode 0, funct 100000), mem_ready tied 1 → state sequence 0,1,6,7,0; reg_write=1 and reg_dst=1 in R_WB only; retired=1 after 4 cycles.
- lw (opcode 100011) with mem_ready low for 3 cycles in MEM_RD → stays in state 3 for 4 cycles with iord=1 and mem_req=1, then MEM_WB with mem_to_reg=1; retired increments once.
- beq with zero=1, then beq with zero=0 → pc_write_cond=1 and pc_source=01 in state 8 for both; each takes 3 cycles; retired=2.
- opcode 111111, and separately R-type with funct 000111 → TRAP (12) from DECODE; illegal=1 and held; retired unchanged; rst_n low clears illegal and returns to FETCH.
- FETCH with mem_ready held 0 → TRAP after exactly 16 wait cycles. mem_ready=1 on the 16th cycle → DECODE instead.
- rst_n pulsed low mid-MEM_WR → mem_req and mem_write drop immediately; after release state=0, retired=0.
